// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl_if
// Description : Configuration, run-control and serial-data bundle for the
//               sequence detector run controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               x;
    logic               x_valid;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;

    // Driver side: offers configuration, control pulses and the bit stream
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, stop, x, x_valid,
        input  cfg_ready, cfg_err, z, match_cnt, busy, done
    );

    // Controller side
    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, stop, x, x_valid,
        output cfg_ready, cfg_err, z, match_cnt, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Run controller around a serial Moore sequence detector.
//               Takes a pattern configuration in IDLE, runs detection on a
//               gated bit stream (overlapping or not) and counts matches up
//               to a programmable target.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Only MAX_LEN-1 past bits are kept: together with the incoming bit they
    // form the full MAX_LEN window, and the oldest one is never compared again.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_z;
    logic               r_cfg_ok;
    logic               r_cfg_err;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;

    logic               w_cfg_fire;
    logic               w_len_legal;
    logic               w_start_run;
    logic               w_bit_take;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_hit_target;

    // Handshake, run-entry and bit-acceptance qualifiers
    always_comb begin
        w_cfg_fire  = bus.cfg_valid && (r_state == S_IDLE);
        w_len_legal = (bus.cfg_len != '0) && (bus.cfg_len <= c_MAX_LEN);
        // A start coinciding with a config handshake is dropped; stop beats start.
        w_start_run = ((r_state == S_IDLE) && bus.start && r_cfg_ok && !bus.cfg_valid) ||
                      ((r_state == S_DONE) && bus.start && !bus.stop);
        // A bit arriving together with stop is discarded.
        w_bit_take  = (r_state == S_RUN) && bus.x_valid && !bus.stop;
    end

    // Window update and pattern comparison on the post-shift history
    always_comb begin
        w_hist_next = {r_hist, bus.x};
        w_fill_next = (r_fill == c_MAX_LEN) ? r_fill : r_fill + LEN_W'(1);
        w_mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_match      = w_bit_take && (w_fill_next >= r_len) &&
                       ((w_hist_next & w_mask) == (r_pattern & w_mask));
        w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        w_hit_target = (r_target != '0) && (w_cnt_inc == r_target);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_state_next = S_IDLE;
                end else if (w_match && w_hit_target) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.stop) begin
                    w_state_next = S_IDLE;
                end else if (w_start_run) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Configuration latch, detection history, match counter and z pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_z       <= 1'b0;
            r_cfg_ok  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_target  <= '0;
        end else begin
            r_z <= 1'b0;
            if (w_cfg_fire) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_overlap <= bus.cfg_overlap;
                r_target  <= bus.cfg_target;
                r_cfg_ok  <= w_len_legal;
                r_cfg_err <= !w_len_legal;
            end
            if (w_start_run) begin
                r_hist <= '0;
                r_fill <= '0;
                r_cnt  <= '0;
            end else if (w_bit_take) begin
                r_hist <= w_hist_next[MAX_LEN-2:0];
                // Non-overlapping mode restarts the window so no bit is reused.
                r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
                if (w_match) begin
                    r_z   <= 1'b1;
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign bus.cfg_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.z         = r_z;
    assign bus.match_cnt = r_cnt;
    assign bus.cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Self-checking bench for seq_det_ctrl: table-driven runs,
//               hand-written corner sequences and a randomized phase checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    logic clk;
    logic rst;

    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus  ();
    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic [7:0] tgt);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.cfg_target  = tgt;
        bus.cfg_valid   = 1'b1;
        tick();
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.x       = b;
        bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: run state plus a queue of the bits that may still
    // take part in a match; a match is the queue tail equal to the pattern.
    // ------------------------------------------------------------------
    int   m_mode;   // 0 idle, 1 run, 2 done
    bit   m_bits[$];
    int   m_cnt;
    bit   m_z, m_ok, m_err, m_ovl;
    bit [7:0] m_pat;
    int   m_len, m_tgt;

    task automatic model_reset();
        m_mode = 0; m_bits.delete(); m_cnt = 0; m_z = 0;
        m_ok = 0; m_err = 0; m_ovl = 0; m_pat = '0; m_len = 0; m_tgt = 0;
    endtask

    task automatic model_step(input bit cv, input bit st, input bit sp,
                              input bit xb, input bit xv);
        bit hit;
        m_z = 0;
        case (m_mode)
            0: begin
                if (cv) begin
                    m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
                    m_ovl = bus.cfg_overlap; m_tgt = int'(bus.cfg_target);
                    m_ok  = (m_len >= 1) && (m_len <= 8);
                    m_err = !m_ok;
                end else if (st && m_ok) begin
                    m_mode = 1; m_bits.delete(); m_cnt = 0;
                end
            end
            1: begin
                if (sp) m_mode = 0;
                else if (xv) begin
                    m_bits.push_back(xb);
                    if (m_bits.size() > 8) void'(m_bits.pop_front());
                    hit = 0;
                    if (m_bits.size() >= m_len) begin
                        hit = 1;
                        for (int j = 0; j < m_len; j++)
                            if (m_bits[m_bits.size()-1-j] != m_pat[j]) hit = 0;
                    end
                    if (hit) begin
                        m_z   = 1;
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                        if (!m_ovl) m_bits.delete();
                        if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
                    end
                end
            end
            default: begin
                if (sp) m_mode = 0;
                else if (st) begin
                    m_mode = 1; m_bits.delete(); m_cnt = 0;
                end
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Directed run table: stream sent MSB first, z mask aligned with it
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [7:0]  tgt;
        logic [15:0] bits;
        int          nb;
        logic [15:0] zm;
        logic [7:0]  cnt;
        logic        dn;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit cv, st, sp, xb, xv;
        int r;

        vecs[0] = '{8'b1011, 4'd4, 1'b1, 8'd0, 16'b0000_1011_0110_1101, 12, 16'b0000_0001_0010_0100, 8'd3, 1'b0};
        vecs[1] = '{8'b1011, 4'd4, 1'b0, 8'd0, 16'b0000_1011_0110_1101, 12, 16'b0000_0001_0000_0100, 8'd2, 1'b0};
        vecs[2] = '{8'b1011, 4'd4, 1'b1, 8'd2, 16'b0000_1011_0110_1101, 12, 16'b0000_0001_0010_0000, 8'd2, 1'b1};
        vecs[3] = '{8'b11,   4'd2, 1'b1, 8'd0, 16'b1111,               4,  16'b0111,               8'd3, 1'b0};
        vecs[4] = '{8'b11,   4'd2, 1'b0, 8'd0, 16'b1111,               4,  16'b0101,               8'd2, 1'b0};
        vecs[5] = '{8'hA5,   4'd8, 1'b1, 8'd0, 16'hA5A5,               16, 16'h0101,               8'd2, 1'b0};

        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.cfg_target = '0; bus.start = 0; bus.stop = 0; bus.x = 0; bus.x_valid = 0;
        bus2.cfg_valid = 0; bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 0;
        bus2.cfg_target = '0; bus2.start = 0; bus2.stop = 0; bus2.x = 0; bus2.x_valid = 0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_done",      bus.done,      0);
        chk("rst_z",         bus.z,         0);
        chk("rst_cnt",       bus.match_cnt, 0);
        chk("rst_cfg_err",   bus.cfg_err,   0);
        do_start();
        chk("rst_start_ignored", bus.busy, 0);

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            send_cfg(vecs[v].pat, vecs[v].len, vecs[v].ovl, vecs[v].tgt);
            chk("tbl_cfg_err", bus.cfg_err, 0);
            do_start();
            chk("tbl_busy_start", bus.busy, 1);
            chk("tbl_cnt_start",  bus.match_cnt, 0);
            for (int i = vecs[v].nb - 1; i >= 0; i--) begin
                send_bit(vecs[v].bits[i]);
                chk($sformatf("tbl%0d_z_bit%0d", v, vecs[v].nb - i), bus.z, vecs[v].zm[i]);
            end
            chk("tbl_cnt_final", bus.match_cnt, vecs[v].cnt);
            chk("tbl_done",      bus.done,      vecs[v].dn);
            chk("tbl_busy_end",  bus.busy,      !vecs[v].dn);
            if (vecs[v].dn) begin
                do_start();
                chk("tbl_restart_cnt",  bus.match_cnt, 0);
                chk("tbl_restart_busy", bus.busy,      1);
                chk("tbl_restart_done", bus.done,      0);
            end
            do_stop();
            chk("tbl_stop_ready", bus.cfg_ready, 1);
        end

        // Gapped input: 111 over bits separated by three idle cycles
        send_cfg(8'b111, 4'd3, 1'b1, 8'd0);
        do_start();
        for (int b = 1; b <= 5; b++) begin
            send_bit(1'b1);
            chk($sformatf("gap_z_bit%0d", b), bus.z, (b >= 3));
            for (int g = 0; g < 3; g++) begin
                tick();
                chk("gap_z_idle", bus.z, 0);
            end
        end
        chk("gap_cnt", bus.match_cnt, 3);
        do_stop();

        // Saturation on the 2-bit counter instance
        bus2.cfg_pattern = 8'b111; bus2.cfg_len = 4'd3; bus2.cfg_overlap = 1'b1;
        bus2.cfg_target = 2'd0; bus2.cfg_valid = 1'b1;
        tick();
        bus2.cfg_valid = 1'b0; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0; bus2.x = 1'b1; bus2.x_valid = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            tick();
            chk($sformatf("sat_cnt_bit%0d", b), bus2.match_cnt, (b <= 2) ? 0 : ((b - 2 > 3) ? 3 : b - 2));
        end
        bus2.x_valid = 1'b0;

        // Illegal configurations
        send_cfg(8'b1011, 4'd0, 1'b1, 8'd0);
        chk("ill_len0_err", bus.cfg_err, 1);
        do_start();
        chk("ill_len0_start_ignored", bus.busy, 0);
        send_cfg(8'b1011, 4'd9, 1'b1, 8'd0);
        chk("ill_len9_err", bus.cfg_err, 1);
        send_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        chk("legal_clears_err", bus.cfg_err, 0);

        // Start in the same cycle as a handshake is dropped
        bus.cfg_valid = 1'b1; bus.start = 1'b1;
        tick();
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        chk("start_with_cfg_ignored", bus.busy, 0);

        // Stop on the bit that completes 1011
        do_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        chk("stopmatch_first_z", bus.z, 1);
        send_bit(0); send_bit(1);
        bus.x = 1'b1; bus.x_valid = 1'b1; bus.stop = 1'b1;
        tick();
        bus.x_valid = 1'b0; bus.stop = 1'b0;
        chk("stopmatch_z",     bus.z,         0);
        chk("stopmatch_idle",  bus.cfg_ready, 1);
        chk("stopmatch_cnt",   bus.match_cnt, 1);

        // Config offered during RUN is stalled
        do_start();
        bus.cfg_len = 4'd0; bus.cfg_valid = 1'b1;
        tick();
        chk("run_cfg_ready", bus.cfg_ready, 0);
        tick();
        bus.cfg_valid = 1'b0;
        chk("run_cfg_not_taken", bus.cfg_err, 0);
        chk("run_still_busy", bus.busy, 1);
        // stop and start together: stop wins
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stop_start_idle", bus.cfg_ready, 1);
        do_start();
        chk("old_cfg_still_ok", bus.busy, 1);

        // Asynchronous reset mid-run
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        chk("pre_rst_cnt", bus.match_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt",   bus.match_cnt, 0);
        chk("async_rst_busy",  bus.busy,      0);
        chk("async_rst_ready", bus.cfg_ready, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        do_start();
        chk("post_rst_start_ignored", bus.busy, 0);

        // Randomized phase against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            cv = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 39) == 0);
            xb = $urandom_range(0, 1);
            xv = ($urandom_range(0, 3) != 0);
            if (cv) begin
                r = $urandom_range(0, 9);
                bus.cfg_len     = (r < 8) ? 4'($urandom_range(1, 4)) :
                                  (r == 8) ? 4'($urandom_range(5, 8)) : 4'($urandom_range(0, 15));
                bus.cfg_pattern = 8'($urandom);
                bus.cfg_overlap = $urandom_range(0, 1);
                bus.cfg_target  = 8'($urandom_range(0, 3));
            end
            bus.cfg_valid = cv; bus.start = st; bus.stop = sp; bus.x = xb; bus.x_valid = xv;
            model_step(cv, st, sp, xb, xv);
            tick();
            chk("rnd_z",         bus.z,         m_z);
            chk("rnd_cnt",       bus.match_cnt, m_cnt);
            chk("rnd_busy",      bus.busy,      (m_mode == 1));
            chk("rnd_done",      bus.done,      (m_mode == 2));
            chk("rnd_cfg_ready", bus.cfg_ready, (m_mode == 0));
            chk("rnd_cfg_err",   bus.cfg_err,   m_err);
        end
        bus.cfg_valid = 0; bus.start = 0; bus.stop = 0; bus.x_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Run controller for the serial Moore sequence detector in the FSM library. It accepts a pattern configuration over a valid/ready handshake and sequences detection runs with start/stop control. It detects the pattern on a gated serial bit stream, in overlapping or non-overlapping mode, and counts matches up to a programmable target.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits (2..16)
- `CNT_W`, 8, width of match counter and target
- `LEN_W`, $clog2(MAX_LEN)+1, width of length field (derived)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous reset, active-high
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration can be taken; equals (state==IDLE)
- `cfg_pattern`  in  MAX_LEN  pattern bits; bit [len-1] is the oldest bit, bit [0] is the newest
- `cfg_len`  in  LEN_W  pattern length; legal range 1..MAX_LEN
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping
- `cfg_target`  in  CNT_W  match count that ends a run; 0 = free-running
- `cfg_err`  out  1  sticky flag: last accepted config had an illegal length
- `start`  in  1  begin run (pulse)
- `stop`  in  1  abort run, return to IDLE (pulse)
- `x`  in  1  serial data bit
- `x_valid`  in  1  x is sampled only when high
- `z`  out  1  registered one-cycle match pulse
- `match_cnt`  out  CNT_W  matches in the current or last run
- `busy`  out  1  state==RUN
- `done`  out  1  state==DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset state: IDLE. Reset values:
  - `z`, `match_cnt`, `cfg_err`, history, fill, and the `cfg_ok` flag are 0.
  - Config registers are 0.
  - `cfg_ready`=1, `busy`=0, `done`=0.
- IDLE:
  - On cfg_valid&cfg_ready, latch pattern, len, overlap, and target.
  - If len is 0 or greater than MAX_LEN, set `cfg_err`=1 and `cfg_ok`=0. Otherwise set `cfg_err`=0 and `cfg_ok`=1.
  - `start` with `cfg_ok`=1 enters RUN. Entry clears history, fill, and `match_cnt`.
  - `start` is ignored if `cfg_ok`=0, or in the same cycle as a config handshake.
- RUN, on x_valid:
  - Shift history: hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - Match condition on the updated history: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0].
- On match:
  - `z`=1 for one cycle.
  - `match_cnt` increments. It saturates at all-ones when target is 0.
  - Non-overlap mode: fill is cleared to 0, so no bit is reused.
  - If target≠0 and the new count equals target, go to DONE.
- RUN, x_valid=0: history, fill, and count hold. Gaps do not break a partial sequence.
- DONE:
  - x is ignored and `match_cnt` holds.
  - `start` re-enters RUN with cleared history and count.
  - `stop` goes to IDLE.
- `stop` in RUN goes to IDLE and `match_cnt` holds.
- Simultaneous events:
  - `stop` and `start` together: stop wins.
  - `stop` together with a matching bit: the bit is discarded, no `z`, no count.
- Config changes are possible only in IDLE. `cfg_valid` outside IDLE is stalled (`cfg_ready`=0).
- Reset mid-run returns immediately to the reset values. Config is lost and `cfg_ok`=0.

## Timing
- Bit sampled at edge k. `z`, `match_cnt`, and a transition to DONE all become visible after edge k, in the same cycle.
- `z` is never high for two consecutive cycles unless matching bits arrive on consecutive edges (overlap, e.g. pattern 11).
- A config handshake at edge k makes `cfg_err`/`cfg_ok` visible after edge k. The earliest effective `start` is at edge k+1.
- A `start` at edge k makes `busy`=1 after edge k. The first bit is sampled at edge k+1.
- `done` goes high in the same cycle as the final `z` pulse.

## Test plan
- Overlap case:
  - Config: pattern 1011, len 4, overlap=1, target 0.
  - Stimulus: start, then stream 1,0,1,1,0,1,1,0,1,1,0,1 with x_valid=1.
  - Required: `z` after bits 4, 7, 10; final `match_cnt`=3.
- Non-overlap case: same stream with overlap=0 → `z` after bits 4 and 10; `match_cnt`=2.
- Target case:
  - Config: pattern 1011, overlap=1, target=2.
  - Required: `done`=1 and `busy`=0 after bit 7, with `match_cnt`=2 thereafter despite bit 10.
  - Then `start` → count 0 and RUN again.
- Gapped input and saturation:
  - Pattern 111, len 3, overlap=1. Bits 1,1,1,1,1 with x_valid low for 3 cycles between each bit.
  - Required: `z` after bits 3, 4, 5; `match_cnt`=3.
  - With CNT_W=2 and 4 matches, `match_cnt` saturates at 3.
- Illegal config:
  - cfg_len=0 → `cfg_err`=1, then `start` ignored (`busy` stays 0).
  - cfg_len=9 with MAX_LEN=8 → `cfg_err`=1.
  - A legal config afterwards clears `cfg_err`.
- Control conflicts and reset:
  - `stop` on the bit completing 1011 → no `z`, IDLE, count unchanged.
  - `cfg_valid` in RUN → `cfg_ready`=0, config not taken.
  - `rst` pulse mid-RUN → IDLE, `match_cnt`=0, `start` ignored until a new legal config.
